// File: rtl/pla_sweep_signature.sv
// rtl/pla_sweep_signature.sv - exhaustive PLA input sweep with MISR signature, on-set count and minterm stream
module pla_sweep_signature #(
    parameter int              N_IN  = 15,
    parameter int              SIG_W = 32,
    parameter logic [SIG_W-1:0] POLY = 32'h04C11DB7,
    parameter logic [SIG_W-1:0] SEED = 32'hFFFFFFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [N_IN-1:0]  x,
    input  logic             y_in,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] signature,
    output logic [N_IN:0]    ones_count,
    output logic             on_valid,
    input  logic             on_ready,
    output logic [N_IN-1:0]  on_vec
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    logic [N_IN-1:0]  r_x;
    logic             r_busy;
    logic             r_done;
    logic [SIG_W-1:0] r_sig;
    logic [N_IN:0]    r_ones;
    logic             r_on_valid;
    logic [N_IN-1:0]  r_on_vec;

    logic             w_handoff;
    logic             w_acc;
    logic             w_last;
    logic             w_drain_exit;
    logic [SIG_W-1:0] w_sig_nxt;
    logic [N_IN:0]    w_ones_nxt;

    // The only stall source is an on-set response arriving while the previous
    // minterm is still waiting in the output register.
    assign w_handoff    = r_on_valid & on_ready;
    assign w_acc        = ~(y_in & r_on_valid & ~on_ready);
    assign w_last       = &r_x;
    // DRAIN may finish in the same cycle that the last minterm is handed off.
    assign w_drain_exit = ~r_on_valid | on_ready;

    assign w_sig_nxt  = {r_sig[SIG_W-2:0], 1'b0}
                      ^ (r_sig[SIG_W-1] ? POLY : {SIG_W{1'b0}})
                      ^ {{(SIG_W-1){1'b0}}, y_in};
    assign w_ones_nxt = r_ones + {{N_IN{1'b0}}, y_in};

    // Sweep controller: vector counter, response compaction and minterm stream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_x        <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sig      <= SEED;
            r_ones     <= '0;
            r_on_valid <= 1'b0;
            r_on_vec   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    // start beats a simultaneous abort here; abort means nothing in IDLE
                    if (start) begin
                        r_state    <= S_SWEEP;
                        r_busy     <= 1'b1;
                        r_x        <= '0;
                        r_sig      <= SEED;
                        r_ones     <= '0;
                        r_on_valid <= 1'b0;
                    end
                end
                S_SWEEP: begin
                    if (abort) begin
                        r_state    <= S_IDLE;
                        r_busy     <= 1'b0;
                        r_on_valid <= 1'b0;
                    end else begin
                        if (w_handoff) begin
                            r_on_valid <= 1'b0;
                        end
                        if (w_acc) begin
                            r_sig  <= w_sig_nxt;
                            r_ones <= w_ones_nxt;
                            // a load in the handoff cycle overrides the clear above
                            if (y_in) begin
                                r_on_vec   <= r_x;
                                r_on_valid <= 1'b1;
                            end
                            if (w_last) begin
                                r_state <= S_DRAIN;
                            end else begin
                                r_x <= r_x + 1'b1;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (abort) begin
                        r_state    <= S_IDLE;
                        r_busy     <= 1'b0;
                        r_on_valid <= 1'b0;
                    end else begin
                        if (w_handoff) begin
                            r_on_valid <= 1'b0;
                        end
                        if (w_drain_exit) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign x          = r_x;
    assign busy       = r_busy;
    assign done       = r_done;
    assign signature  = r_sig;
    assign ones_count = r_ones;
    assign on_valid   = r_on_valid;
    assign on_vec     = r_on_vec;

endmodule

// File: tb/tb_pla_sweep_signature.sv
// tb/tb_pla_sweep_signature.sv - directed self-checking bench for pla_sweep_signature
module tb_pla_sweep_signature;

    localparam int          N    = 11;
    localparam int          NV   = 1 << N;
    localparam logic [31:0] POLY = 32'h04C11DB7;
    localparam logic [31:0] SEED = 32'hFFFFFFFF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          on_ready = 1'b1;
    logic [N-1:0]  x;
    logic          y_in;
    logic          busy;
    logic          done;
    logic [31:0]   signature;
    logic [N:0]    ones_count;
    logic          on_valid;
    logic [N-1:0]  on_vec;

    int n_vec = 0;
    int n_err = 0;
    int mode  = 0;

    int           busy_cyc = 0;
    int           done_cnt = 0;
    int           ov_cnt   = 0;
    logic [N-1:0] ho_q[$];

    pla_sweep_signature #(
        .N_IN (N),
        .SIG_W(32),
        .POLY (POLY),
        .SEED (SEED)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .x         (x),
        .y_in      (y_in),
        .busy      (busy),
        .done      (done),
        .signature (signature),
        .ones_count(ones_count),
        .on_valid  (on_valid),
        .on_ready  (on_ready),
        .on_vec    (on_vec)
    );

    always #5 clk = ~clk;

    // function under test: 0 = constant zero, 1 = x0, 2 = AND of all inputs
    function automatic logic fy(input int m, input logic [N-1:0] v);
        if (m == 1) return v[0];
        if (m == 2) return &v;
        return 1'b0;
    endfunction

    assign y_in = fy(mode, x);

    // golden MISR over the first cnt vectors
    function automatic logic [31:0] misr_ref(input int m, input int cnt);
        logic [31:0]  s;
        logic [N-1:0] xv;
        logic         y;
        s = SEED;
        for (int v = 0; v < cnt; v++) begin
            xv = v[N-1:0];
            y  = fy(m, xv);
            s  = {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ {31'h0, y};
        end
        return s;
    endfunction

    // stream/activity monitor: records minterm handoffs and busy/done cycles
    always @(posedge clk) begin
        if (busy) busy_cyc++;
        if (done) done_cnt++;
        if (on_valid) ov_cnt++;
        if (on_valid && on_ready) ho_q.push_back(on_vec);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_x"}, 64'(x), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_sig"}, 64'(signature), 64'(SEED));
        chk({tag, "_ones"}, 64'(ones_count), 64'(0));
        chk({tag, "_onv"}, 64'(on_valid), 64'(0));
        chk({tag, "_onvec"}, 64'(on_vec), 64'(0));
    endtask

    // full sweep; low_cyc>0 holds on_ready low over the first low_cyc edges
    task automatic run_sweep(input string tag, input int m, input int low_cyc,
                             input bit with_abort, input int exp_ones);
        int b_busy, b_done, b_ov, q0, cyc, stalls, bad, n_ho;
        bit got;
        mode   = m;
        b_busy = busy_cyc;
        b_done = done_cnt;
        b_ov   = ov_cnt;
        q0     = ho_q.size();
        stalls = (low_cyc > 4) ? low_cyc - 4 : 0;
        @(negedge clk);
        start = 1'b1;
        abort = with_abort;
        if (low_cyc > 0) on_ready = 1'b0;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < NV + 200) begin
            @(negedge clk);
            cyc++;
            abort = 1'b0;
            start = (cyc == 50);
            if (cyc == low_cyc) on_ready = 1'b1;
            if (low_cyc > 4 && cyc == 6) begin
                chk({tag, "_stall_x"}, 64'(x), 64'(3));
                chk({tag, "_stall_vec"}, 64'(on_vec), 64'(1));
                chk({tag, "_stall_v"}, 64'(on_valid), 64'(1));
            end
            if (done) got = 1'b1;
        end
        chk({tag, "_done_seen"}, 64'(got), 64'(1));
        chk({tag, "_done_cyc"}, 64'(cyc), 64'(NV + 2 + stalls));
        chk({tag, "_busy_cyc"}, 64'(busy_cyc - b_busy), 64'(NV + 1 + stalls));
        chk({tag, "_busy_in_done"}, 64'(busy), 64'(0));
        chk({tag, "_ones"}, 64'(ones_count), 64'(exp_ones));
        chk({tag, "_sig"}, 64'(signature), 64'(misr_ref(m, NV)));
        // start presented in DONE must be ignored
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_done_width"}, 64'(done), 64'(0));
        chk({tag, "_done_start_ign"}, 64'(busy), 64'(0));
        chk({tag, "_done_pulses"}, 64'(done_cnt - b_done), 64'(1));
        n_ho = ho_q.size() - q0;
        chk({tag, "_stream_len"}, 64'(n_ho), 64'(exp_ones));
        bad = 0;
        for (int k = 0; k < n_ho; k++) begin
            if (m == 1 && ho_q[q0 + k] !== N'(2 * k + 1)) bad++;
            if (m == 2 && ho_q[q0 + k] !== {N{1'b1}}) bad++;
        end
        chk({tag, "_stream_order"}, 64'(bad), 64'(0));
        if (m == 0) chk({tag, "_onv_never"}, 64'(ov_cnt - b_ov), 64'(0));
    endtask

    task automatic wait_x(input string tag, input int target);
        int cyc;
        cyc = 0;
        while (x !== N'(target) && cyc < NV + 10) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
        end
        chk({tag, "_reach_x"}, 64'(x), 64'(target));
    endtask

    initial begin
        int b_done;
        // reset
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // T1: all-zero function, start together with abort in IDLE
        run_sweep("t1", 0, 0, 1'b1, 0);
        // T2: y = x0, free-running consumer
        run_sweep("t2", 1, 0, 1'b0, NV / 2);
        // T3: single minterm at all-ones, handed off in DRAIN
        run_sweep("t3", 2, 0, 1'b0, 1);
        // T4: consumer stalled over the first 14 edges -> 10 stall cycles
        run_sweep("t4", 1, 14, 1'b0, NV / 2);

        // T5: abort at x=100
        mode   = 1;
        b_done = done_cnt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_x("t5", 100);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t5_busy", 64'(busy), 64'(0));
        chk("t5_onv", 64'(on_valid), 64'(0));
        chk("t5_ones", 64'(ones_count), 64'(50));
        chk("t5_sig", 64'(signature), 64'(misr_ref(1, 100)));
        chk("t5_x_hold", 64'(x), 64'(100));
        repeat (5) @(negedge clk);
        chk("t5_no_done", 64'(done_cnt - b_done), 64'(0));
        run_sweep("t5b", 1, 0, 1'b0, NV / 2);

        // T6: asynchronous reset at x=2000
        mode   = 1;
        b_done = done_cnt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_x("t6", 2000);
        #2 rst_n = 1'b0;
        #1 check_reset_values("t6_async");
        @(negedge clk);
        rst_n = 1'b1;
        chk("t6_no_done", 64'(done_cnt - b_done), 64'(0));
        run_sweep("t6b", 1, 0, 1'b0, NV / 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
